// File: rtl/uart_baud_gen.sv
// Programmable UART baud-rate generator: single-cycle oversample and baud enables on sys_clk.
// Define UART_BAUD_FRAC_EN to build the fractional divisor accumulator.
module uart_baud_gen #(
    parameter int DIV_W          = 16,
    parameter int FRAC_W         = 4,
    parameter int OVERSAMPLE     = 16,
    parameter int RESET_DIV_INT  = 78,
    parameter int RESET_DIV_FRAC = 2
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_ack,
    input  logic              resync,
    output logic              os_tick,
    output logic              baud_tick
);

    localparam int                BAUD_W      = $clog2(OVERSAMPLE);
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(OVERSAMPLE - 1);
    localparam logic [BAUD_W-1:0] BAUD_RESYNC = BAUD_W'(OVERSAMPLE - OVERSAMPLE / 2);

    logic [DIV_W:0]     period_cnt;
    logic [DIV_W:0]     eff_int;
    logic [DIV_W:0]     period_len;
    logic [DIV_W-1:0]   act_int;
    logic [DIV_W-1:0]   pend_int;
    logic               pend_flag;
    logic               carry;
    logic [BAUD_W-1:0]  baud_cnt;
    logic               period_end;
    logic               load_now;
    logic               apply;

    assign eff_int    = (act_int == '0) ? {{DIV_W{1'b0}}, 1'b1} : {1'b0, act_int};
    assign period_len = eff_int + {{DIV_W{1'b0}}, carry};
    assign period_end = enable && !resync && ((period_cnt + (DIV_W+1)'(1)) == period_len);

    // A load coinciding with resync bypasses the pending register and is applied immediately.
    assign load_now = enable && resync && div_load;
    assign apply    = load_now || (pend_flag && (!enable || resync || period_end));

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
            baud_cnt   <= '0;
            act_int    <= DIV_W'(RESET_DIV_INT);
            pend_int   <= '0;
            pend_flag  <= 1'b0;
            os_tick    <= 1'b0;
            baud_tick  <= 1'b0;
            div_ack    <= 1'b0;
        end else begin
            div_ack   <= apply;
            os_tick   <= period_end;
            baud_tick <= period_end && (baud_cnt == BAUD_LAST);

            if (div_load) begin
                pend_int <= div_int;
            end
            if (apply) begin
                act_int <= load_now ? div_int : pend_int;
            end

            if (load_now) begin
                pend_flag <= 1'b0;
            end else if (div_load) begin
                pend_flag <= 1'b1;
            end else if (apply) begin
                pend_flag <= 1'b0;
            end

            if (!enable) begin
                period_cnt <= '0;
                baud_cnt   <= '0;
            end else if (resync) begin
                period_cnt <= '0;
                baud_cnt   <= BAUD_RESYNC;
            end else if (period_end) begin
                period_cnt <= '0;
                baud_cnt   <= (baud_cnt == BAUD_LAST) ? '0 : baud_cnt + BAUD_W'(1);
            end else begin
                period_cnt <= period_cnt + (DIV_W+1)'(1);
            end
        end
    end

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] pend_frac;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, act_frac};

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            act_frac  <= FRAC_W'(RESET_DIV_FRAC);
            pend_frac <= '0;
            acc       <= '0;
            carry     <= 1'b0;
        end else begin
            if (div_load) begin
                pend_frac <= div_frac;
            end
            if (apply) begin
                act_frac <= load_now ? div_frac : pend_frac;
            end
            // Carry-out lengthens the following period by one edge.
            if (!enable || resync || apply) begin
                acc   <= '0;
                carry <= 1'b0;
            end else if (period_end) begin
                acc   <= acc_sum[FRAC_W-1:0];
                carry <= acc_sum[FRAC_W];
            end
        end
    end
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^{div_frac, FRAC_W'(RESET_DIV_FRAC)};
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios then random traffic against an event-level model.
// Tick timing is modelled as scheduled period-end edges rather than a cycle counter.
module tb_uart_baud_gen;

    localparam int OS = 4;
    localparam int FW = 4;
    localparam int FM = 1 << FW;
`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [15:0]   div_int;
    logic [3:0]    div_frac;
    logic          div_load;
    logic          div_ack;
    logic          resync;
    logic          os_tick;
    logic          baud_tick;

    uart_baud_gen #(
        .DIV_W(16), .FRAC_W(FW), .OVERSAMPLE(OS), .RESET_DIV_INT(4), .RESET_DIV_FRAC(0)
    ) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable), .div_int(div_int),
        .div_frac(div_frac), .div_load(div_load), .div_ack(div_ack), .resync(resync),
        .os_tick(os_tick), .baud_tick(baud_tick)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_fail = 0;
    int edge_n = 0;
    int mark = 0;
    int ack_n = 0;
    int os_q[$];
    int baud_q[$];
    int ack_q[$];

    // reference model state
    int  a_int, a_frac, p_int, p_frac, acc, carry, ticks, end_edge;
    bit  p_flag, running;
    logic m_os, m_baud, m_ack;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input int q[$], input int idx, input int exp);
        int obs;
        obs = (idx < q.size()) ? q[idx] : -1;
        check(tag, obs, exp);
    endtask

    task automatic model_reset();
        a_int = 4; a_frac = 0; p_int = 0; p_frac = 0; p_flag = 0;
        acc = 0; carry = 0; ticks = 0; running = 0; end_edge = 0;
        m_os = 0; m_baud = 0; m_ack = 0;
    endtask

    task automatic model_apply();
        a_int = p_int; a_frac = p_frac; p_flag = 0; m_ack = 1;
    endtask

    task automatic model_step(input logic en, input logic ld, input int di, input int df, input logic rs);
        int sum;
        m_os = 0; m_baud = 0; m_ack = 0;
        if (!en) begin
            if (p_flag) model_apply();
            if (ld) begin p_int = di; p_frac = df; p_flag = 1; end
            running = 0; acc = 0; carry = 0; ticks = 0;
        end else if (rs) begin
            if (ld) begin p_int = di; p_frac = df; p_flag = 1; end
            if (p_flag) model_apply();
            acc = 0; carry = 0; ticks = OS - OS / 2;
            end_edge = edge_n + eff(a_int);
            running = 1;
        end else begin
            if (!running) begin
                end_edge = edge_n + eff(a_int) - 1;
                running = 1;
            end
            if (edge_n == end_edge) begin
                m_os = 1;
                ticks++;
                m_baud = (ticks % OS == 0);
                if (p_flag) begin
                    model_apply();
                    acc = 0; carry = 0;
                end else begin
                    sum = acc + a_frac;
                    acc = sum % FM;
                    carry = FRAC_ON ? sum / FM : 0;
                end
                end_edge = edge_n + eff(a_int) + carry;
            end
            if (ld) begin p_int = di; p_frac = df; p_flag = 1; end
        end
    endtask

    // Called at a negedge; drives inputs, steps the model on the posedge, samples at the next negedge.
    task automatic cyc(input logic en, input logic ld, input int di, input int df, input logic rs);
        enable = en; div_load = ld; div_int = 16'(di); div_frac = 4'(df); resync = rs;
        @(posedge sys_clk);
        edge_n++;
        model_step(en, ld, di, df, rs);
        @(negedge sys_clk);
        check("os_tick", os_tick, m_os);
        check("baud_tick", baud_tick, m_baud);
        check("div_ack", div_ack, m_ack);
        if (os_tick === 1'b1) os_q.push_back(edge_n - mark);
        if (baud_tick === 1'b1) baud_q.push_back(edge_n - mark);
        if (div_ack === 1'b1) begin ack_q.push_back(edge_n - mark); ack_n++; end
        div_load = 1'b0; resync = 1'b0;
    endtask

    task automatic clear_q();
        os_q.delete(); baud_q.delete(); ack_q.delete(); ack_n = 0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; div_int = 16'd4; div_frac = 4'd0;
        div_load = 1'b0; resync = 1'b0;
        model_reset();

        // reset held with enable high
        repeat (3) begin
            @(negedge sys_clk);
            check("rst_os", os_tick, 0);
            check("rst_baud", baud_tick, 0);
            check("rst_ack", div_ack, 0);
        end
        reset_n = 1'b1;

        // reset divisor 4/0
        clear_q(); mark = edge_n;
        repeat (20) cyc(1, 0, 0, 0, 0);
        check_q("rst_os0", os_q, 0, 4);
        check_q("rst_os1", os_q, 1, 8);
        check_q("rst_os2", os_q, 2, 12);
        check_q("rst_baud0", baud_q, 0, 16);

        // fractional 4/8
        cyc(0, 1, 4, 8, 0);
        cyc(0, 0, 0, 0, 0);
        clear_q(); mark = edge_n;
        repeat (24) cyc(1, 0, 0, 0, 0);
        check_q("frac_os0", os_q, 0, 4);
        check_q("frac_os1", os_q, 1, 8);
        check_q("frac_os2", os_q, 2, FRAC_ON ? 13 : 12);
        check_q("frac_os3", os_q, 3, FRAC_ON ? 17 : 16);
        check_q("frac_os4", os_q, 4, FRAC_ON ? 22 : 20);

        // runtime load, second load overwrites before application
        cyc(0, 1, 4, 0, 0);
        cyc(0, 0, 0, 0, 0);
        clear_q(); mark = edge_n;
        repeat (4) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 7, 0, 0);
        cyc(1, 1, 10, 0, 0);
        repeat (14) cyc(1, 0, 0, 0, 0);
        check("load_ack_count", ack_n, 1);
        check_q("load_ack_at", ack_q, 0, 8);
        check_q("load_os1", os_q, 1, 8);
        check_q("load_os2", os_q, 2, 18);

        // mid-period resync applying a pending 4/0
        cyc(1, 1, 4, 0, 0);
        clear_q(); mark = edge_n + 1;
        cyc(1, 0, 0, 0, 1);
        repeat (30) cyc(1, 0, 0, 0, 0);
        check("rsync_ack_count", ack_n, 1);
        check_q("rsync_os0", os_q, 0, 4);
        check_q("rsync_baud0", baud_q, 0, 8);
        check_q("rsync_baud1", baud_q, 1, 24);

        // resync coincident with a period end
        cyc(1, 0, 0, 0, 0);
        clear_q(); mark = edge_n + 1;
        cyc(1, 0, 0, 0, 1);
        repeat (10) cyc(1, 0, 0, 0, 0);
        check_q("coin_os0", os_q, 0, 4);
        check_q("coin_os1", os_q, 1, 8);

        // enable low for 7 cycles mid-period
        clear_q(); mark = edge_n + 7;
        repeat (7) cyc(0, 0, 0, 0, 0);
        repeat (10) cyc(1, 0, 0, 0, 0);
        check_q("en_os0", os_q, 0, 4);
        check_q("en_os1", os_q, 1, 8);

        // zero divisor gives a tick every cycle
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        clear_q(); mark = edge_n;
        repeat (8) cyc(1, 0, 0, 0, 0);
        check("zero_os_count", os_q.size(), 8);
        check_q("zero_baud0", baud_q, 0, 4);
        check_q("zero_baud1", baud_q, 1, 8);

        // asynchronous reset while os_tick is high
        #2 reset_n = 1'b0;
        #1;
        check("async_os", os_tick, 0);
        check("async_baud", baud_tick, 0);
        check("async_ack", div_ack, 0);
        model_reset();
        @(negedge sys_clk);
        reset_n = 1'b1;
        clear_q(); mark = edge_n;
        repeat (9) cyc(1, 0, 0, 0, 0);
        check_q("post_rst_os0", os_q, 0, 4);
        check_q("post_rst_os1", os_q, 1, 8);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 15) == 0,
                int'($urandom_range(0, 6)), int'($urandom_range(0, 15)),
                $urandom_range(0, 24) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
